// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for an async FIFO: grants one requester per burst and
// frames each burst as a header word (requester index) followed by its data beats.

module fifo_wr_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             gnt,
  input  logic             data_ph,
  input  logic             full,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             wr,
  output logic [WIDTH-1:0] data_sel
);
  assign ready    = gnt & data_ph & ~full;
  assign wr       = ready & valid;
  // grant is one-hot, so masked lane data can simply be OR-reduced at the top
  assign data_sel = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  input  logic                  fifo_wr_full,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]                  state;
  logic [IW-1:0]               gidx, rr_ptr, win_idx;
  logic                        win_vld;
  logic [CW-1:0]               beat_cnt;
  logic [NREQ-1:0]             lane_wr;
  logic [NREQ-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]            beat_data, hdr;
  logic                        beat_wr, beat_last, burst_end;
  int                          idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt     (grant[i]),
      .data_ph (state == S_DATA),
      .full    (fifo_wr_full),
      .valid   (req_valid[i]),
      .data    (req_data[i*WIDTH +: WIDTH]),
      .ready   (req_ready[i]),
      .wr      (lane_wr[i]),
      .data_sel(lane_data[i])
    );
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NREQ; i++) beat_data |= lane_data[i];
  end

  assign beat_wr   = |lane_wr;
  assign beat_last = |(lane_wr & req_last);
  assign burst_end = beat_wr && (beat_last || beat_cnt == CW'(MAX_BURST - 1));

  // first valid requester at or after rr_ptr, cyclically
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    hdr = '0;
    hdr[IW-1:0] = gidx;
  end

  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (state)
      S_HDR: begin
        fifo_wr_en   = ~fifo_wr_full;
        fifo_wr_data = hdr;
      end
      S_DATA: begin
        fifo_wr_en   = beat_wr;
        fifo_wr_data = beat_data;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_vld) begin
          state <= S_HDR;
          grant <= NREQ'(1) << win_idx;
          gidx  <= win_idx;
        end
        S_HDR: if (!fifo_wr_full) begin
          state    <= S_DATA;
          beat_cnt <= '0;
        end
        S_DATA: begin
          if (burst_end) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          end else if (beat_wr) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, and randomized
// traffic against a transaction-level reference model with per-requester beat queues.

module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           wclk = 1'b0;
  logic           rst  = 1'b0;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic           fifo_wr_en, fifo_wr_full, busy;
  logic [W-1:0]   fifo_wr_data;

  fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk(wclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full), .grant(grant), .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef logic [8:0] bq_t[$];
  bq_t          beat_q [N];
  logic [N-1:0] pres, acc, mask;
  logic         rnd_pres, rnd_full, full_now, model_on;
  int           m_owner, m_nb, m_ptr;
  logic         m_hdr;
  logic [W-1:0] wr_log[$];
  logic [W-1:0] exp_log[$];
  int           n_chk = 0, n_pass = 0, cyc = 0;

  typedef struct {
    logic [N-1:0] v; logic [W-1:0] d; logic l; logic f;
    logic e_en; logic [W-1:0] e_d; logic [N-1:0] e_g; logic e_b; logic [N-1:0] e_r;
  } vec_t;
  vec_t tv[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += beat_q[i].size();
    return s;
  endfunction

  task automatic drive();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin void'(beat_q[i].pop_front()); pres[i] = 1'b0; end
      if (beat_q[i].size() == 0) pres[i] = 1'b0;
      else if (!pres[i] && mask[i] && (!rnd_pres || $urandom_range(0, 2) != 0)) pres[i] = 1'b1;
      b = (beat_q[i].size() > 0) ? beat_q[i][0] : 9'($urandom);
      req_valid[i]       = pres[i];
      req_data[i*W +: W] = pres[i] ? b[7:0] : 8'($urandom);
      req_last[i]        = pres[i] ? b[8] : 1'($urandom_range(0, 1));
    end
    acc = '0;
    fifo_wr_full = rnd_full ? ($urandom_range(0, 3) == 0) : full_now;
  endtask

  // Reference: owner index, header-pending flag, beats so far; data checked against queue.
  task automatic model_step();
    logic [N-1:0] er, eg;
    logic         ee, eb, dchk;
    logic [W-1:0] ed;
    logic [8:0]   b;
    int           nxt;
    if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
    if (!model_on) return;
    er = '0; eg = '0; ee = 1'b0; eb = 1'b0; dchk = 1'b0; ed = '0; nxt = -1; b = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (nxt < 0 && req_valid[j]) nxt = j;
      end
    end else begin
      eg[m_owner] = 1'b1;
      eb = 1'b1;
      if (m_hdr) begin
        ee = !fifo_wr_full; ed = W'(m_owner); dchk = ee;
      end else begin
        er[m_owner] = !fifo_wr_full;
        ee = req_valid[m_owner] && !fifo_wr_full;
        if (ee) begin b = beat_q[m_owner][0]; ed = b[7:0]; dchk = 1'b1; end
      end
    end
    chk("ready", 32'(req_ready), 32'(er));
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
    chk("wr_en", 32'(fifo_wr_en), 32'(ee));
    if (dchk) chk("wr_data", 32'(fifo_wr_data), 32'(ed));
    if (m_owner < 0) begin
      if (nxt >= 0) begin m_owner = nxt; m_hdr = 1'b1; end
    end else if (m_hdr) begin
      if (!fifo_wr_full) begin m_hdr = 1'b0; m_nb = 0; end
    end else if (ee) begin
      acc[m_owner] = 1'b1;
      m_nb++;
      if (b[8] || m_nb == MB) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
    end
  endtask

  task automatic cyc_step();
    drive();
    @(negedge wclk);
    model_step();
    @(posedge wclk); #1;
    cyc++;
  endtask

  task automatic run_until_empty(int maxc);
    int k = 0;
    while ((pending() > 0 || m_owner >= 0) && k < maxc) begin cyc_step(); k++; end
    chk("drain_in_budget", 32'(k < maxc), 32'd1);
    cyc_step();
  endtask

  task automatic check_log(string name);
    chk({name, "_len"}, 32'(wr_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      chk(name, 32'(wr_log[i]), 32'(exp_log[i]));
  endtask

  task automatic do_reset(bit check);
    rst = 1'b0;
    #1;
    if (check) begin
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    end
    for (int i = 0; i < N; i++) beat_q[i].delete();
    pres = '0; acc = '0; mask = '1; full_now = 1'b0; rnd_pres = 1'b0; rnd_full = 1'b0;
    m_owner = -1; m_hdr = 1'b0; m_nb = 0; m_ptr = 0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_wr_full = 1'b0;
    @(posedge wclk); #1;
    @(posedge wclk); #1;
    rst = 1'b1;
    wr_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{v:4'b0010, d:8'hA1, l:0, f:0, e_en:0, e_d:8'h00, e_g:4'b0000, e_b:0, e_r:4'b0000};
    tv[1] = '{v:4'b0010, d:8'hA1, l:0, f:0, e_en:1, e_d:8'h01, e_g:4'b0010, e_b:1, e_r:4'b0000};
    tv[2] = '{v:4'b0010, d:8'hA1, l:0, f:0, e_en:1, e_d:8'hA1, e_g:4'b0010, e_b:1, e_r:4'b0010};
    tv[3] = '{v:4'b0010, d:8'hA2, l:0, f:0, e_en:1, e_d:8'hA2, e_g:4'b0010, e_b:1, e_r:4'b0010};
    tv[4] = '{v:4'b0010, d:8'hA3, l:1, f:0, e_en:1, e_d:8'hA3, e_g:4'b0010, e_b:1, e_r:4'b0010};
    tv[5] = '{v:4'b0000, d:8'h00, l:0, f:0, e_en:0, e_d:8'h00, e_g:4'b0000, e_b:0, e_r:4'b0000};
    tv[6] = '{v:4'b0000, d:8'h00, l:0, f:0, e_en:0, e_d:8'h00, e_g:4'b0000, e_b:0, e_r:4'b0000};

    model_on = 1'b0;
    req_valid = '1; req_data = '1; req_last = '1; fifo_wr_full = 1'b0;
    @(posedge wclk); #1;
    do_reset(1);

    // single requester, vector table
    for (int t = 0; t < 7; t++) begin
      req_valid = tv[t].v; req_data = '0; req_data[1*W +: W] = tv[t].d;
      req_last = '0; req_last[1] = tv[t].l; fifo_wr_full = tv[t].f;
      @(negedge wclk);
      chk("tv_wr_en", 32'(fifo_wr_en), 32'(tv[t].e_en));
      if (tv[t].e_en) chk("tv_wr_data", 32'(fifo_wr_data), 32'(tv[t].e_d));
      chk("tv_grant", 32'(grant), 32'(tv[t].e_g));
      chk("tv_busy", 32'(busy), 32'(tv[t].e_b));
      chk("tv_ready", 32'(req_ready), 32'(tv[t].e_r));
      @(posedge wclk); #1;
      cyc++;
    end
    model_on = 1'b1;

    // round-robin with 1-beat bursts
    do_reset(0);
    for (int i = 0; i < N; i++) begin
      beat_q[i].push_back({1'b1, 8'(8'h10 + i)});
      beat_q[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    run_until_empty(100);
    exp_log = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13,
                8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23};
    check_log("rr_order");

    // full during header and mid-data
    do_reset(0);
    beat_q[1] = '{{1'b0, 8'hB1}, {1'b0, 8'hB2}, {1'b0, 8'hB3}, {1'b1, 8'hB4}};
    for (int c = 0; c < 12; c++) begin
      full_now = (c >= 1 && c <= 3) || c == 7 || c == 8;
      cyc_step();
    end
    full_now = 1'b0;
    run_until_empty(50);
    exp_log = '{8'h01, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    check_log("bp_order");

    // forced release at MAX_BURST with a competing requester
    do_reset(0);
    for (int i = 1; i <= 6; i++) beat_q[2].push_back({1'(i == 6), 8'(8'hC0 + i)});
    beat_q[3] = '{{1'b0, 8'hD1}, {1'b1, 8'hD2}};
    run_until_empty(100);
    exp_log = '{8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h03, 8'hD1, 8'hD2, 8'h02, 8'hC5, 8'hC6};
    check_log("mb_order");

    // mid-burst stall by the owner
    do_reset(0);
    beat_q[0] = '{{1'b0, 8'hE1}, {1'b0, 8'hE2}, {1'b1, 8'hE3}};
    beat_q[1] = '{{1'b1, 8'hF1}};
    for (int c = 0; c < 10; c++) begin
      mask[0] = !(c >= 3 && c <= 7);
      cyc_step();
      if (c == 5) chk("stall_grant", 32'(grant), 32'b0001);
    end
    mask = '1;
    run_until_empty(50);
    exp_log = '{8'h00, 8'hE1, 8'hE2, 8'hE3, 8'h01, 8'hF1};
    check_log("stall_order");

    // reset mid-burst; pointer would otherwise favour requester 2
    do_reset(0);
    beat_q[0] = '{{1'b1, 8'h61}};
    beat_q[2] = '{{1'b0, 8'h71}, {1'b0, 8'h72}, {1'b1, 8'h73}};
    for (int c = 0; c < 7; c++) cyc_step();
    drive();
    do_reset(1);
    beat_q[0] = '{{1'b1, 8'h81}};
    beat_q[2] = '{{1'b1, 8'h91}};
    run_until_empty(50);
    exp_log = '{8'h00, 8'h81, 8'h02, 8'h91};
    check_log("rst_order");

    // randomized traffic
    do_reset(0);
    for (int i = 0; i < N; i++) begin
      for (int bst = 0; bst < 30; bst++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) beat_q[i].push_back({1'(k == len - 1), 8'($urandom)});
      end
    end
    rnd_pres = 1'b1; rnd_full = 1'b1;
    for (int c = 0; c < 1500; c++) cyc_step();
    rnd_full = 1'b0;
    run_until_empty(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of an asynchronous FIFO among NREQ requesters, all running on the FIFO write clock. It grants one requester at a time for a whole burst, in round-robin order. Each burst goes into the FIFO as a header word carrying the requester index, followed by the data beats, so the read-clock consumer can demultiplex. It sits directly in front of the FIFO write interface and respects its full flag.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, FIFO data width; must satisfy WIDTH >= $clog2(NREQ).
- MAX_BURST, 16, maximum data beats per grant (>= 1); the grant is forcibly released after this many beats.

Ports:
- wclk  input  1  write-domain clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester data-valid.
- req_data  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  input  NREQ  marks the final beat of a burst; sampled only with an accepted beat.
- req_ready  output  NREQ  per-requester accept; a beat transfers when valid && ready.
- fifo_wr_en  output  1  write strobe to the FIFO.
- fifo_wr_data  output  WIDTH  write data to the FIFO.
- fifo_wr_full  input  1  FIFO full flag, in the wclk domain.
- grant  output  NREQ  one-hot current owner; all-zero when no burst is in progress.
- busy  output  1  high while state is HDR or DATA.

## Operation
- States: IDLE, HDR, DATA.
- **IDLE**
  - If any req_valid bit is high, select one requester by round-robin.
  - Search starts at index rr_ptr and wraps modulo NREQ.
  - Register the winner into grant and go to HDR.
  - Otherwise stay in IDLE.
- **HDR**
  - fifo_wr_data = winner index, zero-extended to WIDTH.
  - fifo_wr_en = !fifo_wr_full.
  - When written, go to DATA and clear the beat counter.
  - While full, hold in HDR.
- **DATA**
  - req_ready[g] = !fifo_wr_full, where g is the granted index; all other ready bits are 0.
  - fifo_wr_en = req_valid[g] && !fifo_wr_full.
  - fifo_wr_data = req_data[g].
  - Each accepted beat increments the beat counter, which is $clog2(MAX_BURST)+1 bits wide.
- **Burst end:** occurs on an accepted beat that has req_last[g]=1, or that is the MAX_BURST-th beat. At burst end:
  - Go to IDLE.
  - Clear grant.
  - Set rr_ptr = (g+1) mod NREQ.
- **Forced release:** a burst cut at MAX_BURST is not marked specially. The requester's next beats form a new burst with a new header once it is re-granted.
- **Stalls:** if req_valid[g] drops mid-burst, the arbiter stays in DATA holding the grant and writes nothing. There is no timeout.
- **Non-granted requesters** see ready=0 and must hold their valid and data.
- **No overflow:** fifo_wr_en is never asserted while fifo_wr_full=1.

## Timing
- **Reset values** (while rst=0): state IDLE, grant 0, rr_ptr 0, beat counter 0. Therefore busy=0, fifo_wr_en=0, req_ready=0, and fifo_wr_data=0.
- **Reset mid-burst:** the burst is abandoned immediately, with no further writes. After release, arbitration restarts from requester 0.
- **Combinational paths:** req_ready, fifo_wr_en and fifo_wr_data are combinational from state, grant, req_* and fifo_wr_full. There are no registered outputs other than grant.
- **Latency with FIFO not full:**
  - Cycle 0: req_valid seen in IDLE.
  - Cycle 1: header written.
  - Cycle 2: first data beat written.
  - After that, one beat per cycle.
- **Between bursts:** there is one IDLE cycle after each burst end. Minimum overhead is 2 cycles per burst (header + IDLE).
- **Simultaneous requests:** the lowest index at or after rr_ptr, cyclically, wins. A requester that has just been served has the lowest priority in the next arbitration.
- **Burst end with full:** last beat and full in the same cycle means no transfer and no burst end. The burst ends on the cycle the beat is actually written.

## Test plan
- **Single requester:** requester 1 sends a 3-beat burst (0xA1, 0xA2, 0xA3 with last) while the FIFO is empty. Required response:
  - FIFO receives 0x01, 0xA1, 0xA2, 0xA3 on consecutive cycles 1–4.
  - grant = 0b0010 during the burst.
  - busy falls on cycle 5.
- **Round-robin:** all four requesters hold valid with 1-beat bursts from reset. Required response:
  - Headers appear in order 0, 1, 2, 3, 0, 1.
  - Each grant lasts 2 cycles, followed by 1 IDLE cycle.
- **Full backpressure:** force fifo_wr_full=1 during HDR for 3 cycles, and later for 2 cycles mid-DATA. Required response:
  - No fifo_wr_en while full.
  - req_ready=0 while full.
  - Data order is preserved with no duplicate or lost beats.
- **MAX_BURST=4 forced release:** requester 2 streams 6 beats with last only on beat 6, while requester 3 is also requesting. Required response, in order:
  - Header 0x02 followed by 4 beats.
  - Header 0x03 and requester 3's burst.
  - Header 0x02 followed by the remaining 2 beats.
- **Mid-burst stall:** requester 0 drops valid for 5 cycles inside a burst while requester 1 requests. Required response:
  - grant stays 0b0001 and no writes occur during the stall.
  - Requester 1 is granted only after requester 0's last beat.
- **Reset mid-burst:** assert rst=0 during DATA, then release. Required response:
  - All outputs reach their reset values in the same cycle.
  - With requesters 0 and 2 valid, the first header after reset is 0x00.
